// File: rtl/coin_acceptor_if.sv
// Coin acceptor link: slot sensor and ticket in, coin code, gates and queue status out.
// The acceptor itself uses the slave modport; the environment driving it uses master.
interface coin_acceptor_if;
    logic       coin_detect;
    logic [7:0] coin_weight;
    logic       ticket;
    logic [1:0] coin;
    logic       accept_gate;
    logic       reject_gate;
    logic       fifo_full;

    modport master (
        output coin_detect, coin_weight, ticket,
        input  coin, accept_gate, reject_gate, fifo_full
    );

    modport slave (
        input  coin_detect, coin_weight, ticket,
        output coin, accept_gate, reject_gate, fifo_full
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the slot, classifies the coin by weight, pulses the cashbox or
// return gate and presents accepted coins to vending_machine as one-cycle codes.
module coin_acceptor #(
    parameter int         DEBOUNCE    = 3,
    parameter logic [7:0] NICKEL_MIN  = 8'd45,
    parameter logic [7:0] NICKEL_MAX  = 8'd55,
    parameter logic [7:0] DIME_MIN    = 8'd20,
    parameter logic [7:0] DIME_MAX    = 8'd25,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         GATE_CYCLES = 8
) (
    input logic            clk,
    input logic            rst,
    coin_acceptor_if.slave bus
);
    localparam logic [1:0] PENNY  = 2'd0;
    localparam logic [1:0] NICKEL = 2'd1;
    localparam logic [1:0] DIME   = 2'd2;

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_C     = CW'(DEBOUNCE);
    localparam logic [AW:0]   FULL_C    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DEB, MEAS, CLASS, WAIT_CLR} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [7:0]      weight_p0;
    logic            latch, push, pop, start_acc, start_rej, gate_busy;
    logic [1:0]      code;
    logic            accept_q, reject_q, full_q;
    logic [GW-1:0]   gcnt;
    logic [1:0]      coin_q;
    logic [1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nxt;

    // Nickel window is tested first so it wins if the windows ever overlap.
    function automatic logic [1:0] classify(input logic [7:0] w);
        if (w >= NICKEL_MIN && w <= NICKEL_MAX) return NICKEL;
        if (w >= DIME_MIN && w <= DIME_MAX)     return DIME;
        return PENNY;
    endfunction

    assign gate_busy = accept_q | reject_q;
    assign code      = classify(weight_p0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        push      = 1'b0;
        start_acc = 1'b0;
        start_rej = 1'b0;
        case (state)
            IDLE: begin
                if (bus.coin_detect) begin
                    state_nxt = DEB;
                    cnt_nxt   = CW'(1);
                end
            end
            DEB: begin
                if (!bus.coin_detect)  state_nxt = IDLE;
                else if (cnt < DEB_C)  cnt_nxt   = cnt + 1'b1;
                else                   state_nxt = MEAS;
            end
            MEAS: begin
                latch     = 1'b1;
                state_nxt = CLASS;
            end
            CLASS: begin
                // A full queue bounces the coin back rather than losing it.
                if (code != PENNY && !full_q) begin
                    push      = 1'b1;
                    start_acc = 1'b1;
                end else begin
                    start_rej = 1'b1;
                end
                state_nxt = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!bus.coin_detect && !gate_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            gcnt     <= '0;
        end else if (start_acc) begin
            accept_q <= 1'b1;
            gcnt     <= GATE_LAST;
        end else if (start_rej) begin
            reject_q <= 1'b1;
            gcnt     <= GATE_LAST;
        end else if (gate_busy) begin
            if (gcnt == '0) begin
                accept_q <= 1'b0;
                reject_q <= 1'b0;
            end else begin
                gcnt <= gcnt - 1'b1;
            end
        end
    end

    // Requiring coin==0 forces an idle cycle after every code so ticket is seen in between.
    assign pop = (count != '0) && !bus.ticket && (coin_q == PENNY);

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + 1'b1;
        else if (!push && pop) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
            coin_q <= PENNY;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            full_q <= (count_nxt == FULL_C);
            coin_q <= pop ? mem[rd_ptr] : PENNY;
        end
    end

    always_ff @(posedge clk) begin
        if (push)  mem[wr_ptr] <= code;
        if (latch) weight_p0   <= bus.coin_weight;
    end

    assign bus.coin        = coin_q;
    assign bus.accept_gate = accept_q;
    assign bus.reject_gate = reject_q;
    assign bus.fifo_full   = full_q;
endmodule
